// File: rtl/muon_pkg.sv
// muon_pkg: shared sequencer state encoding and counter widths.
package muon_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DEAD    = 2'd3
    } state_t;
    localparam int EVW   = 32;
    localparam int DRW   = 16;
    localparam int DEADW = 16;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through event FIFO; a full FIFO still takes a push alongside a pop.
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [FW-1:0] fill_q;
    logic          wr, rd;
    assign empty = fill_q == '0;
    assign full  = fill_q == FW'(DEPTH);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign fill  = fill_q;
    assign rdata = empty ? '0 : mem_q[rp_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fill_q <= '0;
        end else if (clr) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fill_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + AW'(1);
            if (rd) rp_q <= rp_q + AW'(1);
            fill_q <= fill_q + FW'(wr) - FW'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr && !clr) mem_q[wp_q] <= wdata;
    end
endmodule

// File: rtl/muon_decay_sequencer.sv
// muon_decay_sequencer: arms the trigger datapath, captures double-pulse delta times into a FIFO
// and enforces a post-event dead time.
module muon_decay_sequencer
    import muon_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [15:0]            dead_cycles,
    input  logic                   double_trig,
    input  logic [DW-1:0]          delta_time,
    output logic                   arm,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [DW-1:0]          ev_data,
    output logic [$clog2(DEPTH):0] fill,
    output logic [31:0]            event_count,
    output logic [15:0]            drop_count
);
    state_t            state_q, state_d;
    logic              run_q, trig_q, arm_q;
    logic [DW-1:0]     lat_q;
    logic [DEADW-1:0]  dead_q;
    logic [EVW-1:0]    evc_q;
    logic [DRW-1:0]    drc_q;
    logic              full, empty, push, pop, acc, rise;
    assign rise        = double_trig && !trig_q;
    assign push        = state_q == CAPTURE && !clear;
    assign pop         = ev_ready && !empty;
    assign acc         = push && (!full || pop);
    assign arm         = arm_q;
    assign ev_valid    = !empty;
    assign event_count = evc_q;
    assign drop_count  = drc_q;
    // run_q holds the FSM in IDLE for the first edge after reset release
    always_comb begin
        state_d = !run_q ? IDLE :
                  state_q == IDLE    ? (enable ? ARMED : IDLE) :
                  state_q == ARMED   ? (!enable ? IDLE : rise ? CAPTURE : ARMED) :
                  state_q == CAPTURE ? DEAD :
                  dead_q > DEADW'(1) ? DEAD : enable ? ARMED : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            trig_q  <= 1'b0;
            arm_q   <= 1'b0;
            lat_q   <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            trig_q  <= double_trig;
            arm_q   <= state_d == ARMED;
            if (state_d == CAPTURE) lat_q <= delta_time;
            dead_q  <= state_q == CAPTURE ? dead_cycles :
                       dead_q != '0 ? dead_q - DEADW'(1) : dead_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evc_q <= '0;
            drc_q <= '0;
        end else if (clear) begin
            evc_q <= '0;
            drc_q <= '0;
        end else begin
            if (acc && evc_q != '1) evc_q <= evc_q + EVW'(1);
            if (push && !acc && drc_q != '1) drc_q <= drc_q + DRW'(1);
        end
    end
    event_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .push  (push),
        .pop   (pop),
        .wdata (lat_q),
        .rdata (ev_data),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );
endmodule

// File: tb/tb_muon_decay_sequencer.sv
// tb_muon_decay_sequencer: vector table for the single-event timeline plus directed corner sequences.
module tb_muon_decay_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] dead_cycles = 16'd10;
    logic        double_trig = 1'b0;
    logic [15:0] delta_time = 16'h0;
    logic        ev_ready = 1'b0;
    logic        arm, ev_valid;
    logic [15:0] ev_data;
    logic [4:0]  fill;
    logic [31:0] event_count;
    logic [15:0] drop_count;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        en;
        logic [15:0] dead;
        logic        trig;
        logic [15:0] delta;
        logic        rdy;
        logic        arm;
        logic        vld;
        logic [15:0] data;
        logic [4:0]  fill;
        logic [31:0] evc;
        logic [15:0] drc;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    muon_decay_sequencer #(.DEPTH(16), .DW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .dead_cycles (dead_cycles),
        .double_trig (double_trig),
        .delta_time  (delta_time),
        .arm         (arm),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .fill        (fill),
        .event_count (event_count),
        .drop_count  (drop_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [15:0] d);
        double_trig = 1'b1;
        delta_time  = d;
        step();
        double_trig = 1'b0;
        repeat (3) step();
    endtask

    task automatic chk_all(input string nm, input logic a, input logic v, input logic [15:0] d,
                           input logic [4:0] f, input logic [31:0] e, input logic [15:0] r);
        chk({nm, " arm"}, arm, a);
        chk({nm, " valid"}, ev_valid, v);
        chk({nm, " data"}, ev_data, d);
        chk({nm, " fill"}, fill, f);
        chk({nm, " evc"}, event_count, e);
        chk({nm, " drc"}, drop_count, r);
    endtask

    initial begin
        tbl[0]  = '{1, 10, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0};
        tbl[1]  = '{1, 10, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0};
        tbl[2]  = '{1, 10, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0};
        tbl[3]  = '{1, 10, 1, 16'h0123, 0, 0, 0, 16'h0000, 0, 0, 0};
        tbl[4]  = '{1, 10, 1, 16'hffff, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[5]  = '{1, 10, 0, 16'hffff, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[6]  = '{1, 10, 0, 16'hffff, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[7]  = '{1, 10, 0, 16'hffff, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[8]  = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[9]  = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[10] = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[11] = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[12] = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[13] = '{1, 10, 1, 16'h0456, 0, 0, 1, 16'h0123, 1, 1, 0};
        tbl[14] = '{1, 10, 1, 16'h0456, 0, 1, 1, 16'h0123, 1, 1, 0};
        tbl[15] = '{1, 10, 1, 16'h0456, 0, 1, 1, 16'h0123, 1, 1, 0};
        tbl[16] = '{1, 10, 0, 16'h0456, 0, 1, 1, 16'h0123, 1, 1, 0};
        tbl[17] = '{1, 10, 0, 16'h0456, 1, 1, 0, 16'h0000, 0, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 16'h0, 0, 0, 0);
        #2 rst = 1'b0;

        // single event, dead time, ignored second edge, held level, then pop
        for (int i = 0; i < 18; i++) begin
            enable      = tbl[i].en;
            dead_cycles = tbl[i].dead;
            double_trig = tbl[i].trig;
            delta_time  = tbl[i].delta;
            ev_ready    = tbl[i].rdy;
            step();
            chk_all($sformatf("row%0d", i), tbl[i].arm, tbl[i].vld, tbl[i].data,
                    tbl[i].fill, tbl[i].evc, tbl[i].drc);
        end

        // fill to overflow with ev_ready low
        ev_ready = 1'b0;
        double_trig = 1'b0;
        dead_cycles = 16'd0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr0 evc", event_count, 0);
        for (int i = 0; i < 17; i++) fire(16'h1000 + 16'(i));
        chk_all("full", 1, 1, 16'h1000, 16, 16, 1);

        // push and pop in the same cycle while full
        double_trig = 1'b1;
        delta_time  = 16'h2000;
        step();
        double_trig = 1'b0;
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("pp fill", fill, 16);
        chk("pp evc", event_count, 17);
        chk("pp drc", drop_count, 1);
        chk("pp head", ev_data, 16'h1001);
        repeat (2) step();
        chk("pp stable", ev_data, 16'h1001);
        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pop%0d", i), ev_data, i < 15 ? 16'h1001 + 16'(i) : 16'h2000);
            step();
        end
        chk("drain fill", fill, 0);
        chk("drain valid", ev_valid, 0);
        step();
        chk("pop empty fill", fill, 0);
        ev_ready = 1'b0;

        // clear with fill=5 while the FSM keeps running
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) fire(16'h0500 + 16'(i));
        chk("pre clr fill", fill, 5);
        chk("pre clr evc", event_count, 5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_all("clr", 1, 0, 16'h0, 0, 0, 0);
        fire(16'h0777);
        chk("post clr fill", fill, 1);
        chk("post clr evc", event_count, 1);
        chk("post clr data", ev_data, 16'h0777);

        // async reset in DEAD with fill=3
        fire(16'h0888);
        dead_cycles = 16'd10;
        double_trig = 1'b1;
        delta_time  = 16'h0999;
        step();
        double_trig = 1'b0;
        repeat (2) step();
        chk("dead arm", arm, 0);
        chk("dead fill", fill, 3);
        rst = 1'b1;
        #1;
        chk_all("async rst", 0, 0, 16'h0, 0, 0, 0);
        #2 rst = 1'b0;
        step();
        chk("rel edge1 arm", arm, 0);
        step();
        chk("rel edge2 arm", arm, 1);

        // reset during CAPTURE loses the event
        dead_cycles = 16'd0;
        double_trig = 1'b1;
        delta_time  = 16'h0aaa;
        step();
        rst = 1'b1;
        #1 rst = 1'b0;
        double_trig = 1'b0;
        repeat (2) step();
        chk_all("cap rst", 1, 0, 16'h0, 0, 0, 0);
        fire(16'h0bbb);
        chk("after cap rst data", ev_data, 16'h0bbb);
        chk("after cap rst evc", event_count, 1);

        // enable drop returns to IDLE, re-enable re-arms
        enable = 1'b0;
        step();
        chk("disable arm", arm, 0);
        enable = 1'b1;
        step();
        chk("reenable arm", arm, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muon_decay_sequencer.md
MUON_DECAY_SEQUENCER -- requirements
Module: muon_decay_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, event FIFO depth (power of 2, 4..256).
REQ-002 SHALL have parameter DW, default 16, delta-time word width.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, run request.
REQ-006 SHALL have port clear, input, 1, synchronous flush of FIFO and counters.
REQ-007 SHALL have port dead_cycles, input, 16, post-event hold-off length.
REQ-008 SHALL have port double_trig, input, 1, double-pulse flag from trigger datapath.
REQ-009 SHALL have port delta_time, input, DW, pulse separation from trigger datapath.
REQ-010 SHALL have port arm, output, 1, trigger datapath enabled.
REQ-011 SHALL have port ev_valid, output, 1, FIFO head valid.
REQ-012 SHALL have port ev_ready, input, 1, consumer accepts head.
REQ-013 SHALL have port ev_data, output, DW, FIFO head delta time.
REQ-014 SHALL have port fill, output, log2(DEPTH)+1, FIFO occupancy.
REQ-015 SHALL have port event_count, output, 32, accepted events.
REQ-016 SHALL have port drop_count, output, 16, events lost to full FIFO.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, CAPTURE, DEAD; arm = (state==ARMED), registered.
REQ-018 IDLE->ARMED when enable=1; ARMED->IDLE when enable=0, next cycle.
REQ-019 In ARMED, rising edge of double_trig (high at cycle N, low at N-1) SHALL latch delta_time at N and enter CAPTURE at N+1; double_trig level held high SHALL NOT re-trigger.
REQ-020 CAPTURE SHALL last exactly one cycle: push latched word, then enter DEAD.
REQ-021 DEAD SHALL last max(dead_cycles,1) cycles, then ARMED if enable=1 else IDLE; enable drop during DEAD SHALL NOT shorten it.
REQ-022 Edges outside ARMED SHALL be ignored and not counted.
REQ-023 Push SHALL be accepted if fill<DEPTH or a pop occurs the same cycle; accepted push increments event_count, rejected push increments drop_count.
REQ-024 FIFO SHALL be first-word-fall-through: ev_valid = (fill!=0); pop when ev_valid&&ev_ready; ev_data stable while ev_valid&&!ev_ready.
REQ-025 Latency: edge at N into empty FIFO SHALL give ev_valid=1 with ev_data=latched word at N+2.
REQ-026 Simultaneous push and pop SHALL leave fill unchanged; pop on empty SHALL be ignored.
REQ-027 event_count and drop_count SHALL saturate at all-ones, not wrap.
REQ-028 clear SHALL, next cycle, zero fill, event_count, drop_count and drop any push in that cycle; FSM state unaffected.
REQ-029 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 rst SHALL asynchronously force state=IDLE, arm=0, fill=0, ev_valid=0, ev_data=0, event_count=0, drop_count=0, edge-detect register=0.
REQ-031 Deassertion SHALL be synchronous to clk; first possible arm at second clk edge after release with enable=1.
REQ-032 rst mid-CAPTURE SHALL discard the latched event without counting it.

Structure
REQ-033 FSM state encoding and counter widths SHALL live in shared package muon_pkg.
REQ-034 FIFO SHALL be sub-module event_fifo (params DEPTH, DW; push/pop/full/empty/fill).
REQ-035 Implementation SHALL be 120-400 lines RTL, no vendor primitives.

Verification
REQ-036 enable=1, dead_cycles=10, double_trig pulse with delta_time=0x0123 -> ev_valid at edge+2, ev_data=0x0123, event_count=1, arm low 11 cycles.
REQ-037 Second edge 5 cycles after first, dead_cycles=10 -> ignored, event_count=1, drop_count=0.
REQ-038 ev_ready=0, 17 spaced events, DEPTH=16 -> fill=16, event_count=16, drop_count=1; then pops return words in order.
REQ-039 FIFO full, push and pop same cycle -> push accepted, fill stays 16, drop_count unchanged.
REQ-040 rst asserted mid-DEAD with fill=3 -> all outputs zero immediately, state IDLE, no clk edge needed.
REQ-041 clear with fill=5, event_count=5 -> next cycle fill=0, ev_valid=0, counters 0, FSM continues.
